allocate_register_file_sb: RTL and testbench
============================================

Name: allocate_register_file_sb

Overview:
Parametrised successor to the allocate-stage general register file. It keeps one storage copy per read port, with combinational reads and one write port. It adds four things:
- a post-reset zero-initialisation sequence;
- same-cycle write-to-read bypass;
- an optional hardwired zero register;
- a per-register pending scoreboard, set at allocate and cleared at writeback, so the allocate stage can detect RAW hazards.

Parameters:
P_DATA_W, 32, register data width in bits
P_ADDR_W, 5, address width; depth P_DEPTH = 2**P_ADDR_W
P_BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return stored contents only
P_ZERO_REG, 0, 1 = register 0 always reads 0, never pending, and ignores writes and allocates

Ports:
iCLOCK  in  1  system clock, all state updates on posedge
iRESET_SYNC  in  1  synchronous active-high reset
oINIT_BUSY  out  1  high while the zero-initialisation sequence runs
iWR_VALID  in  1  writeback strobe
iWR_ADDR  in  P_ADDR_W  writeback register index
iWR_DATA  in  P_DATA_W  writeback data
iALLOC_VALID  in  1  allocate strobe; marks the destination pending
iALLOC_ADDR  in  P_ADDR_W  destination register index
iFLUSH  in  1  clears all pending bits (pipeline flush)
iRD0_ADDR  in  P_ADDR_W  read port 0 index
oRD0_DATA  out  P_DATA_W  read port 0 data, combinational
oRD0_PENDING  out  1  read port 0 register has an outstanding producer
iRD1_ADDR  in  P_ADDR_W  read port 1 index
oRD1_DATA  out  P_DATA_W  read port 1 data, combinational
oRD1_PENDING  out  1  read port 1 register has an outstanding producer

Behaviour:
- Clock and reset: one clock, iCLOCK. Reset iRESET_SYNC is synchronous and active-high, sampled only on the posedge of iCLOCK.
- Storage: two identical arrays, one per read port. Every accepted write updates both arrays at the same edge.

State machine (states INIT, RUN) and reset:
- iRESET_SYNC high at an edge puts the block in INIT, clears the init counter to 0, and clears all pending bits.
- Reset asserted mid-INIT restarts the counter at 0.
- In INIT, each cycle writes 0 to entry[counter] in both arrays, then increments the counter.
- The transition to RUN happens on the edge that writes entry P_DEPTH-1. INIT therefore lasts exactly P_DEPTH cycles after reset deasserts.
- oINIT_BUSY = 1 in INIT and while reset is asserted; it is 0 in RUN.

In INIT:
- iWR_VALID, iALLOC_VALID and iFLUSH are ignored.
- oRDn_DATA = 0 and oRDn_PENDING = 0.

Write (RUN):
- iWR_VALID at an edge writes iWR_DATA into entry[iWR_ADDR] in both arrays, and clears pending[iWR_ADDR].
- With P_ZERO_REG = 1, a write to index 0 is dropped.

Allocate (RUN):
- iALLOC_VALID at an edge sets pending[iALLOC_ADDR].
- With P_ZERO_REG = 1, an allocate to index 0 is dropped.

Pending-bit priority at one edge, highest first: iFLUSH, then allocate-set, then write-clear.
- Allocate and write to the same index in the same cycle: the bit ends at 1, because the new producer wins. The data write still occurs.
- iFLUSH high: all bits end at 0, including a simultaneous allocate target. A simultaneous data write still occurs.

Read (RUN, fully combinational, zero latency):
- oRDn_DATA = entry[iRDn_ADDR] from the port's own array.
- With P_BYPASS = 1 and iWR_VALID && iWR_ADDR == iRDn_ADDR (an accepted write): oRDn_DATA = iWR_DATA and oRDn_PENDING = 0 in that cycle.
- Otherwise oRDn_PENDING = pending[iRDn_ADDR].
- With P_ZERO_REG = 1 and iRDn_ADDR == 0: data = 0 and pending = 0, regardless of bypass.
- Both ports may read the same index simultaneously. Results are identical.

Width and sizing:
- No arithmetic on data.
- The init counter is P_ADDR_W+1 bits wide, or terminal-compare on P_DEPTH-1; it must not wrap into a second pass.
- Outputs must never be X after reset, since every entry is written during INIT.

Test Plan:
1. Reset, then P_ADDR_W = 5: assert iRESET_SYNC for 2 cycles, release -> oINIT_BUSY stays 1 for exactly 32 cycles, then drops. Reading all 32 indices on both ports returns 0 with pending 0.
2. Bypass and write: in RUN, iWR_VALID = 1, iWR_ADDR = 7, iWR_DATA = 0xDEADBEEF with iRD0_ADDR = iRD1_ADDR = 7:
   - P_BYPASS = 1 -> both ports read 0xDEADBEEF in the same cycle.
   - P_BYPASS = 0 -> both ports read the old value 0, then 0xDEADBEEF the next cycle.
3. Scoreboard: allocate index 3 -> the next cycle oRD0_PENDING = 1 for index 3. Write index 3 with 0x55 -> the cycle after, pending = 0 and data = 0x55. Simultaneous allocate and write on index 3 -> pending = 1, data updated.
4. Flush: allocate indices 1, 2, 9 on consecutive cycles, then iFLUSH together with allocate of index 4 -> all pending bits read 0, including index 4.
5. P_ZERO_REG = 1: write 0x1234 to index 0 and allocate index 0 -> index 0 reads 0 with pending 0. Same-cycle bypass to index 0 also returns 0.
6. Reset mid-operation:
   - Assert reset at init count 10 -> the full 32-cycle INIT restarts.
   - Assert reset in RUN with pending bits set and writes in flight -> all pending bits cleared and all data zeroed after INIT. Writes issued during INIT have no effect.

Source files
------------

// File: rtl/allocate_register_file_sb.sv
// Allocate-stage register file: one storage copy per read port, zero-init after reset,
// optional write-to-read bypass and hardwired zero register, plus a RAW pending scoreboard.
module allocate_register_file_sb #(
    parameter int P_DATA_W   = 32,
    parameter int P_ADDR_W   = 5,
    parameter int P_BYPASS   = 1,
    parameter int P_ZERO_REG = 0
) (
    input  logic                iCLOCK,
    input  logic                iRESET_SYNC,
    output logic                oINIT_BUSY,
    input  logic                iWR_VALID,
    input  logic [P_ADDR_W-1:0] iWR_ADDR,
    input  logic [P_DATA_W-1:0] iWR_DATA,
    input  logic                iALLOC_VALID,
    input  logic [P_ADDR_W-1:0] iALLOC_ADDR,
    input  logic                iFLUSH,
    input  logic [P_ADDR_W-1:0] iRD0_ADDR,
    output logic [P_DATA_W-1:0] oRD0_DATA,
    output logic                oRD0_PENDING,
    input  logic [P_ADDR_W-1:0] iRD1_ADDR,
    output logic [P_DATA_W-1:0] oRD1_DATA,
    output logic                oRD1_PENDING
);
    localparam int P_DEPTH = 2 ** P_ADDR_W;
    localparam logic [P_ADDR_W:0] L_LAST = (P_ADDR_W + 1)'(P_DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                r_state, w_state_nxt;
    logic [P_ADDR_W:0]     r_init_cnt, w_init_cnt_nxt;
    logic [P_DATA_W-1:0]   r_mem0 [P_DEPTH];
    logic [P_DATA_W-1:0]   r_mem1 [P_DEPTH];
    logic [P_DEPTH-1:0]    r_pend, w_pend_nxt;
    logic                  w_run, w_init_we, w_wr_ok, w_alloc_ok;

    // Reset asserted this cycle overrides RUN, so nothing is accepted during the reset edge.
    assign w_run      = (r_state == S_RUN) && !iRESET_SYNC;
    assign w_init_we  = (r_state == S_INIT) && !iRESET_SYNC;
    assign oINIT_BUSY = !w_run;
    assign w_wr_ok    = w_run && iWR_VALID && !((P_ZERO_REG != 0) && (iWR_ADDR == '0));
    assign w_alloc_ok = w_run && iALLOC_VALID && !((P_ZERO_REG != 0) && (iALLOC_ADDR == '0));

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        if (r_state == S_INIT) begin
            w_init_cnt_nxt = r_init_cnt + (P_ADDR_W + 1)'(1);
            if (r_init_cnt == L_LAST) begin
                w_state_nxt = S_RUN;
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (w_init_we) begin
            r_mem0[r_init_cnt[P_ADDR_W-1:0]] <= '0;
            r_mem1[r_init_cnt[P_ADDR_W-1:0]] <= '0;
        end else if (w_wr_ok) begin
            r_mem0[iWR_ADDR] <= iWR_DATA;
            r_mem1[iWR_ADDR] <= iWR_DATA;
        end
    end

    // Flush beats allocate-set, which beats write-clear (a new producer wins).
    always_comb begin
        w_pend_nxt = r_pend;
        if (iRESET_SYNC || (w_run && iFLUSH)) begin
            w_pend_nxt = '0;
        end else begin
            if (w_wr_ok)    w_pend_nxt[iWR_ADDR]    = 1'b0;
            if (w_alloc_ok) w_pend_nxt[iALLOC_ADDR] = 1'b1;
        end
    end

    always_ff @(posedge iCLOCK) begin
        r_pend <= w_pend_nxt;
    end

    always_comb begin
        oRD0_DATA    = '0;
        oRD0_PENDING = 1'b0;
        if (w_run && !((P_ZERO_REG != 0) && (iRD0_ADDR == '0))) begin
            if ((P_BYPASS != 0) && w_wr_ok && (iWR_ADDR == iRD0_ADDR)) begin
                oRD0_DATA = iWR_DATA;
            end else begin
                oRD0_DATA    = r_mem0[iRD0_ADDR];
                oRD0_PENDING = r_pend[iRD0_ADDR];
            end
        end
    end

    always_comb begin
        oRD1_DATA    = '0;
        oRD1_PENDING = 1'b0;
        if (w_run && !((P_ZERO_REG != 0) && (iRD1_ADDR == '0))) begin
            if ((P_BYPASS != 0) && w_wr_ok && (iWR_ADDR == iRD1_ADDR)) begin
                oRD1_DATA = iWR_DATA;
            end else begin
                oRD1_DATA    = r_mem1[iRD1_ADDR];
                oRD1_PENDING = r_pend[iRD1_ADDR];
            end
        end
    end
endmodule

// File: tb/tb_allocate_register_file_sb.sv
// Two instances (bypass/no-zero-reg and no-bypass/zero-reg) share stimulus and are
// compared every cycle against an array-based reference model.
module tb_allocate_register_file_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_v, al_v, flush;
    logic [AW-1:0] wr_a, al_a, rd0_a, rd1_a;
    logic [DW-1:0] wr_d;

    logic          busy [2];
    logic [DW-1:0] rd_d [2][2];
    logic          rd_p [2][2];

    int n_chk = 0;
    int n_err = 0;

    // Model state
    logic [DW-1:0] m_mem  [2][DEPTH];
    bit            m_pend [2][DEPTH];
    int            m_init_left;
    int            byp [2] = '{1, 0};
    int            zr  [2] = '{0, 1};

    always #5 clk = ~clk;

    allocate_register_file_sb #(.P_DATA_W(DW), .P_ADDR_W(AW), .P_BYPASS(1), .P_ZERO_REG(0)) u_dut0 (
        .iCLOCK(clk), .iRESET_SYNC(rst), .oINIT_BUSY(busy[0]),
        .iWR_VALID(wr_v), .iWR_ADDR(wr_a), .iWR_DATA(wr_d),
        .iALLOC_VALID(al_v), .iALLOC_ADDR(al_a), .iFLUSH(flush),
        .iRD0_ADDR(rd0_a), .oRD0_DATA(rd_d[0][0]), .oRD0_PENDING(rd_p[0][0]),
        .iRD1_ADDR(rd1_a), .oRD1_DATA(rd_d[0][1]), .oRD1_PENDING(rd_p[0][1])
    );

    allocate_register_file_sb #(.P_DATA_W(DW), .P_ADDR_W(AW), .P_BYPASS(0), .P_ZERO_REG(1)) u_dut1 (
        .iCLOCK(clk), .iRESET_SYNC(rst), .oINIT_BUSY(busy[1]),
        .iWR_VALID(wr_v), .iWR_ADDR(wr_a), .iWR_DATA(wr_d),
        .iALLOC_VALID(al_v), .iALLOC_ADDR(al_a), .iFLUSH(flush),
        .iRD0_ADDR(rd0_a), .oRD0_DATA(rd_d[1][0]), .oRD0_PENDING(rd_p[1][0]),
        .iRD1_ADDR(rd1_a), .oRD1_DATA(rd_d[1][1]), .oRD1_PENDING(rd_p[1][1])
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit            m_busy;
        logic [AW-1:0] ra;
        logic [DW-1:0] ed;
        bit            ep;
        m_busy = rst || (m_init_left > 0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("busy%0d", k), {31'd0, busy[k]}, {31'd0, m_busy});
            for (int p = 0; p < 2; p++) begin
                ra = (p == 0) ? rd0_a : rd1_a;
                ed = '0;
                ep = 1'b0;
                if (!m_busy && !(zr[k] == 1 && ra == 0)) begin
                    if (byp[k] == 1 && wr_v && wr_a == ra) begin
                        ed = wr_d;
                    end else begin
                        ed = m_mem[k][ra];
                        ep = m_pend[k][ra];
                    end
                end
                chk($sformatf("i%0d_rd%0d_data[%0d]", k, p, ra), rd_d[k][p], ed);
                chk($sformatf("i%0d_rd%0d_pend[%0d]", k, p, ra), {31'd0, rd_p[k][p]}, {31'd0, ep});
            end
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_init_left = DEPTH;
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < DEPTH; i++) m_pend[k][i] = 1'b0;
        end else if (m_init_left > 0) begin
            for (int k = 0; k < 2; k++) m_mem[k][DEPTH - m_init_left] = '0;
            m_init_left--;
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit w_ok, a_ok;
                w_ok = wr_v && !(zr[k] == 1 && wr_a == 0);
                a_ok = al_v && !(zr[k] == 1 && al_a == 0);
                if (w_ok) m_mem[k][wr_a] = wr_d;
                if (flush) begin
                    for (int i = 0; i < DEPTH; i++) m_pend[k][i] = 1'b0;
                end else begin
                    if (w_ok) m_pend[k][wr_a] = 1'b0;
                    if (a_ok) m_pend[k][al_a] = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr_v = 0; al_v = 0; flush = 0; rst = 0;
    endtask

    initial begin
        m_init_left = DEPTH;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[k][i] = 'x;
                m_pend[k][i] = 1'b0;
            end
        idle();
        wr_a = '0; al_a = '0; wr_d = '0; rd0_a = '0; rd1_a = '0;
        rst = 1;
        cycle(); cycle();
        rst = 0;
        // INIT window plus an all-index sweep once RUN is reached
        for (int i = 0; i < 2 * DEPTH; i++) begin
            rd0_a = AW'(i); rd1_a = AW'(DEPTH - 1 - i);
            cycle();
        end
        // bypass on index 7
        wr_v = 1; wr_a = 7; wr_d = 32'hDEADBEEF; rd0_a = 7; rd1_a = 7;
        cycle();
        idle(); cycle();
        // scoreboard on index 3
        al_v = 1; al_a = 3; rd0_a = 3; rd1_a = 3;
        cycle();
        idle(); cycle();
        wr_v = 1; wr_a = 3; wr_d = 32'h55;
        cycle();
        idle(); cycle();
        wr_v = 1; wr_a = 3; wr_d = 32'hA5A5; al_v = 1; al_a = 3;
        cycle();
        idle(); cycle();
        // flush wins over simultaneous allocate
        for (int i = 0; i < 3; i++) begin
            al_v = 1; al_a = (i == 0) ? 5'd1 : (i == 1) ? 5'd2 : 5'd9;
            rd0_a = 1; rd1_a = 2;
            cycle();
        end
        al_v = 1; al_a = 4; flush = 1;
        cycle();
        idle();
        rd0_a = 1; rd1_a = 9; cycle();
        rd0_a = 2; rd1_a = 4; cycle();
        // zero register: write + allocate to 0, bypass read of 0
        wr_v = 1; wr_a = 0; wr_d = 32'h1234; al_v = 1; al_a = 0; rd0_a = 0; rd1_a = 0;
        cycle();
        idle(); cycle();
        // reset at init count 10, then writes issued during the restarted INIT
        al_v = 1; al_a = 12; cycle();
        wr_v = 1; wr_a = 12; wr_d = 32'hCAFE; al_v = 1; al_a = 13; rst = 1;
        cycle();
        idle();
        for (int i = 0; i < 10; i++) cycle();
        rst = 1; cycle();
        rst = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            wr_v = 1; wr_a = AW'($urandom); wr_d = $urandom;
            al_v = 1; al_a = AW'($urandom); flush = $urandom_range(0, 1);
            rd0_a = AW'(i); rd1_a = 12;
            cycle();
        end
        // randomized traffic, narrow address range to force collisions
        for (int n = 0; n < 1500; n++) begin
            wr_v  = ($urandom_range(0, 99) < 60);
            wr_a  = AW'($urandom_range(0, 7));
            wr_d  = $urandom;
            al_v  = ($urandom_range(0, 99) < 50);
            al_a  = AW'($urandom_range(0, 7));
            flush = ($urandom_range(0, 99) < 4);
            rst   = ($urandom_range(0, 299) == 0);
            rd0_a = ($urandom_range(0, 3) == 0) ? wr_a : AW'($urandom_range(0, 7));
            rd1_a = ($urandom_range(0, 3) == 0) ? rd0_a : AW'($urandom);
            cycle();
        end
        idle();
        cycle();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
